// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer: load-use bubbles, data-memory freeze, taken-branch IF/ID flush.
// Latency: 0 cycles -- control outputs are combinational from registered state and current inputs.
// Backpressure: Mem_Ready low with a MEM access freezes the whole pipe and pauses any bubble sequence.
module pipeline_hazard_controller #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int CNT_W            = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             MemRead_ID_EX,
    input  logic [4:0]       Rt_ID_EX,
    input  logic [4:0]       Rs_IF_ID,
    input  logic [4:0]       Rt_IF_ID,
    input  logic             Uses_Rt_IF_ID,
    input  logic             Branch_Taken,
    input  logic             MemAccess_EX_MEM,
    input  logic             Mem_Ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             Pipe_Freeze,
    output logic             Busy,
    output logic [CNT_W-1:0] Stall_Cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // Bubbles still owed after the one issued in the detecting cycle.
    localparam logic [2:0]       LU_INIT  = 3'(LOAD_USE_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q;

    logic mem_wait;
    logic lu;

    assign mem_wait = MemAccess_EX_MEM & ~Mem_Ready;
    // r0 is hardwired zero, so a load into it never creates a real dependency.
    assign lu = MemRead_ID_EX & (Rt_ID_EX != 5'd0) &
                ((Rt_ID_EX == Rs_IF_ID) | (Uses_Rt_IF_ID & (Rt_ID_EX == Rt_IF_ID)));

    // Next-state and same-cycle pipeline control; priority is mem_wait > load-use > branch.
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        Pipe_Freeze  = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;

        if (Reset) begin
            // Drain IF/ID and ID/EX while reset is held.
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            state_d      = RUN;
            cnt_d        = 3'd0;
        end else begin
            unique case (state_q)
                LU_STALL: begin
                    if (mem_wait) begin
                        // Bubble sequence pauses; cnt and state hold.
                        Pipe_Freeze = 1'b1;
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                    end else begin
                        // Branch_Taken ignored: the branch stays in ID and re-resolves later.
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                        if (cnt_q <= 3'd1) begin
                            state_d = RUN;
                            cnt_d   = 3'd0;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
                default: begin
                    // RUN and MEM_WAIT behave alike: leaving MEM_WAIT evaluates as RUN in the same cycle.
                    if (mem_wait) begin
                        Pipe_Freeze = 1'b1;
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        state_d     = MEM_WAIT;
                    end else if (lu) begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                        if (LOAD_USE_BUBBLES > 1) begin
                            state_d = LU_STALL;
                            cnt_d   = LU_INIT;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = RUN;
                        if (Branch_Taken) begin
                            IF_ID_Flush = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign Busy         = (state_q != RUN);
    assign Stall_Cycles = stall_q;

    // State and bubble counter registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_q <= '0;
        end else if (!PC_Write && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller; three instances share one stimulus:
// single-bubble (16-bit count), triple-bubble (16-bit count), single-bubble (4-bit count).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
module tb_pipeline_hazard_controller;

    logic       clk;
    logic       rst;
    logic       mr;
    logic [4:0] rte, rs, rt;
    logic       urt, bt, ma, mrdy;

    logic        a_pc, a_ifw, a_fl, a_bub, a_frz, a_busy;
    logic [15:0] a_cnt;
    logic        b_pc, b_ifw, b_fl, b_bub, b_frz, b_busy;
    logic [15:0] b_cnt;
    logic        s_pc, s_ifw, s_fl, s_bub, s_frz, s_busy;
    logic [3:0]  s_cnt;

    int total = 0;
    int bad   = 0;

    pipeline_hazard_controller #(.LOAD_USE_BUBBLES(1), .CNT_W(16)) u_b1 (
        .Clk(clk), .Reset(rst), .MemRead_ID_EX(mr), .Rt_ID_EX(rte), .Rs_IF_ID(rs),
        .Rt_IF_ID(rt), .Uses_Rt_IF_ID(urt), .Branch_Taken(bt), .MemAccess_EX_MEM(ma),
        .Mem_Ready(mrdy), .PC_Write(a_pc), .IF_ID_Write(a_ifw), .IF_ID_Flush(a_fl),
        .ID_EX_Bubble(a_bub), .Pipe_Freeze(a_frz), .Busy(a_busy), .Stall_Cycles(a_cnt));

    pipeline_hazard_controller #(.LOAD_USE_BUBBLES(3), .CNT_W(16)) u_b3 (
        .Clk(clk), .Reset(rst), .MemRead_ID_EX(mr), .Rt_ID_EX(rte), .Rs_IF_ID(rs),
        .Rt_IF_ID(rt), .Uses_Rt_IF_ID(urt), .Branch_Taken(bt), .MemAccess_EX_MEM(ma),
        .Mem_Ready(mrdy), .PC_Write(b_pc), .IF_ID_Write(b_ifw), .IF_ID_Flush(b_fl),
        .ID_EX_Bubble(b_bub), .Pipe_Freeze(b_frz), .Busy(b_busy), .Stall_Cycles(b_cnt));

    pipeline_hazard_controller #(.LOAD_USE_BUBBLES(1), .CNT_W(4)) u_sat (
        .Clk(clk), .Reset(rst), .MemRead_ID_EX(mr), .Rt_ID_EX(rte), .Rs_IF_ID(rs),
        .Rt_IF_ID(rt), .Uses_Rt_IF_ID(urt), .Branch_Taken(bt), .MemAccess_EX_MEM(ma),
        .Mem_Ready(mrdy), .PC_Write(s_pc), .IF_ID_Write(s_ifw), .IF_ID_Flush(s_fl),
        .ID_EX_Bubble(s_bub), .Pipe_Freeze(s_frz), .Busy(s_busy), .Stall_Cycles(s_cnt));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        mr = 1'b0; rte = 5'd0; rs = 5'd0; rt = 5'd0; urt = 1'b0;
        bt = 1'b0; ma = 1'b0; mrdy = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load r5 in EX, ID reads Rs=r5.
    task automatic hazard();
        mr = 1'b1; rte = 5'd5; rs = 5'd5; rt = 5'd9; urt = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        chk("rst_pc",    a_pc,   1'b0);
        chk("rst_ifw",   a_ifw,  1'b0);
        chk("rst_flush", a_fl,   1'b1);
        chk("rst_bub",   a_bub,  1'b1);
        chk("rst_frz",   a_frz,  1'b0);
        chk("rst_busy",  a_busy, 1'b0);
        chk("rst_cnt",   a_cnt,  16'd0);
        step();
        chk("rst_hold_cnt", b_cnt, 16'd0);
        rst = 1'b0;
        #1;
        chk("idle_pc",  a_pc, 1'b1);
        chk("idle_fl",  a_fl, 1'b0);
        chk("idle_bub", a_bub, 1'b0);

        // Load-use: one bubble for b1, three for b3.
        hazard();
        #1;
        chk("lu1_pc",   a_pc,   1'b0);
        chk("lu1_ifw",  a_ifw,  1'b0);
        chk("lu1_bub",  a_bub,  1'b1);
        chk("lu3_c1_pc",   b_pc,   1'b0);
        chk("lu3_c1_busy", b_busy, 1'b0);
        step();
        idle();
        bt = 1'b1;
        #1;
        chk("lu1_after_pc",   a_pc,  1'b1);
        chk("lu1_after_bub",  a_bub, 1'b0);
        chk("lu1_cnt",        a_cnt, 16'd1);
        chk("br_flush_b1",    a_fl,  1'b1);
        chk("br_pc_b1",       a_pc,  1'b1);
        chk("lu3_c2_pc",      b_pc,  1'b0);
        chk("lu3_c2_busy",    b_busy, 1'b1);
        chk("lu3_c2_noflush", b_fl,  1'b0);
        chk("lu3_c2_bub",     b_bub, 1'b1);
        step();
        bt = 1'b0;
        #1;
        chk("lu3_c3_pc",   b_pc,   1'b0);
        chk("lu3_c3_busy", b_busy, 1'b1);
        step();
        #1;
        chk("lu3_c4_pc",   b_pc,   1'b1);
        chk("lu3_c4_busy", b_busy, 1'b0);
        chk("lu3_cnt",     b_cnt,  16'd3);
        chk("sat_cnt_1",   s_cnt,  4'd1);

        // No-stall cases: load into r0; Rt match with Uses_Rt clear.
        mr = 1'b1; rte = 5'd0; rs = 5'd0; rt = 5'd0; urt = 1'b1;
        #1;
        chk("r0_pc_b1", a_pc, 1'b1);
        chk("r0_pc_b3", b_pc, 1'b1);
        rte = 5'd7; rs = 5'd3; rt = 5'd7; urt = 1'b0;
        #1;
        chk("nort_pc", a_pc, 1'b1);
        urt = 1'b1;
        #1;
        chk("rt_match_pc", a_pc, 1'b0);
        idle();
        #1;
        step();

        // Memory wait in the middle of a 3-bubble stall.
        hazard();
        #1;
        step();
        idle();
        ma = 1'b1; mrdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mw_frz_b3", b_frz, 1'b1);
            chk("mw_pc_b3",  b_pc,  1'b0);
            chk("mw_bub_b3", b_bub, 1'b0);
            step();
        end
        chk("mw_busy_b1", a_busy, 1'b1);
        ma = 1'b0; mrdy = 1'b1;
        #1;
        chk("mw_exit_frz_b3", b_frz, 1'b0);
        chk("mw_exit_bub_b3", b_bub, 1'b1);
        chk("mw_exit_pc_b1",  a_pc,  1'b1);
        chk("mw_exit_busy_b1", a_busy, 1'b1);
        step();
        #1;
        chk("mw_bub2_b3", b_bub, 1'b1);
        chk("mw_busy_b1_run", a_busy, 1'b0);
        step();
        #1;
        chk("mw_done_pc_b3", b_pc, 1'b1);
        chk("mw_cnt_b3", b_cnt, 16'd10);
        chk("mw_cnt_b1", a_cnt, 16'd6);

        // Branch and load-use together: stall wins, no flush.
        hazard();
        bt = 1'b1;
        #1;
        chk("brlu_bub", a_bub, 1'b1);
        chk("brlu_fl",  a_fl,  1'b0);
        chk("brlu_pc",  a_pc,  1'b0);
        step();
        idle();
        step();
        step();
        #1;
        chk("brlu_cnt_b1", a_cnt, 16'd7);
        chk("brlu_cnt_b3", b_cnt, 16'd13);
        chk("brlu_cnt_sat", s_cnt, 4'd7);

        // Reset asserted while in MEM_WAIT.
        ma = 1'b1; mrdy = 1'b0;
        step();
        #1;
        chk("pre_rst_busy", a_busy, 1'b1);
        chk("pre_rst_frz",  a_frz,  1'b1);
        rst = 1'b1;
        #1;
        chk("arst_pc",   a_pc,   1'b0);
        chk("arst_fl",   a_fl,   1'b1);
        chk("arst_bub",  a_bub,  1'b1);
        chk("arst_frz",  a_frz,  1'b0);
        chk("arst_busy", a_busy, 1'b0);
        chk("arst_cnt",  a_cnt,  16'd0);
        step();
        rst = 1'b0;
        ma = 1'b0; mrdy = 1'b1;
        #1;
        chk("post_rst_busy", a_busy, 1'b0);
        chk("post_rst_pc",   a_pc,   1'b1);
        chk("post_rst_cnt",  a_cnt,  16'd0);

        // Saturation: 20 frozen cycles on a 4-bit counter.
        ma = 1'b1; mrdy = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("sat_at_15", s_cnt, 4'd15);
        for (int i = 0; i < 5; i++) step();
        chk("sat_hold", s_cnt, 4'd15);
        chk("nosat_b1", a_cnt, 16'd20);
        chk("nosat_b3", b_cnt, 16'd20);
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
